mu0_mem_bridge: RTL and testbench

//  Memory-side neighbour of the MU0 control FSM. Consumes its memrq/rnw strobes plus the datapath address/ACC bus.

---
 rtl/mu0_pkg.sv | 25 ++
 rtl/mu0_mem_bridge_if.sv | 30 +++
 rtl/mu0_wait_timer.sv | 26 ++
 rtl/mu0_mem_bridge.sv | 135 +++++++++++++
 tb/tb_mu0_mem_bridge.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared MU0 constants: bridge state encoding, bus widths, opcodes
package mu0_pkg;

    localparam int MU0_AW = 12;
    localparam int MU0_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } bridge_state_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7
    } mu0_opcode_t;

endpackage

// File: rtl/mu0_mem_bridge_if.sv
// rtl/mu0_mem_bridge_if.sv - req/ack memory bus between the bridge and the memory
interface mu0_mem_bridge_if #(
    parameter int AW = mu0_pkg::MU0_AW,
    parameter int DW = mu0_pkg::MU0_DW
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mu0_wait_timer.sv
// rtl/mu0_wait_timer.sv - clear/enable wait counter with terminal-count flag
module mu0_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // count ack-less busy cycles; clear wins over enable
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // terminal count marks the last busy cycle the memory is allowed
    assign o_tc = (r_count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mu0_mem_bridge.sv
// rtl/mu0_mem_bridge.sv - MU0 CPU-to-memory req/ack bridge with stall and bus watchdog
module mu0_mem_bridge
    import mu0_pkg::*;
#(
    parameter int AW      = MU0_AW,
    parameter int DW      = MU0_DW,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cpu_memrq,
    input  logic                i_cpu_rnw,
    input  logic [AW-1:0]       i_cpu_addr,
    input  logic [DW-1:0]       i_cpu_wdata,
    output logic [DW-1:0]       o_cpu_rdata,
    output logic                o_stall,
    output logic                o_bus_err,
    mu0_mem_bridge_if.master    mem
);
    bridge_state_t r_state;
    bridge_state_t w_state_next;

    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic          r_bus_err;

    logic          w_capture;
    logic          w_ack_done;
    logic          w_timeout;
    logic          w_timer_clear;
    logic          w_timer_en;
    logic          w_tc;

    mu0_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_tc     (w_tc)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state and per-cycle strobes; ack beats the watchdog in the same cycle
    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_ack_done    = 1'b0;
        w_timeout     = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_memrq) begin
                    w_capture     = 1'b1;
                    w_timer_clear = 1'b1;
                    w_state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem.mem_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_timer_en = 1'b1;
                    if (w_tc) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // bus-side latches, read-data capture and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= ~i_cpu_rnw;
                r_mem_addr  <= i_cpu_addr;
                r_mem_wdata <= i_cpu_wdata;
            end
            if (w_ack_done) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_cpu_rdata <= mem.mem_rdata;
                end
            end
            if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_bus_err <= 1'b1;
            end
        end
    end

    // stall is combinational so the CPU freezes in the very cycle it raises memrq
    assign o_stall = !rst && ((r_state == ST_IDLE && i_cpu_memrq) ||
                              r_state == ST_BUSY || r_state == ST_ERR);

    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_bus_err     = r_bus_err;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mu0_mem_bridge.sv
// tb/tb_mu0_mem_bridge.sv - randomized scoreboard bench for mu0_mem_bridge
module tb_mu0_mem_bridge;
    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cpu_memrq;
    logic          i_cpu_rnw;
    logic [AW-1:0] i_cpu_addr;
    logic [DW-1:0] i_cpu_wdata;
    logic [DW-1:0] o_cpu_rdata;
    logic          o_stall;
    logic          o_bus_err;

    mu0_mem_bridge_if #(.AW(AW), .DW(DW)) bus ();

    mu0_mem_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cpu_memrq (i_cpu_memrq),
        .i_cpu_rnw   (i_cpu_rnw),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .o_cpu_rdata (o_cpu_rdata),
        .o_stall     (o_stall),
        .o_bus_err   (o_bus_err),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            delay;
    } mem_txn_t;

    typedef struct {
        int            delay;
        logic [DW-1:0] rdata;
    } cpl_t;

    mem_txn_t mem_q[$];
    cpl_t     cpl_q[$];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    bit            auto_ack   = 1'b0;
    bit            mon_en     = 1'b0;
    logic          resp_ack   = 1'b0;
    logic [DW-1:0] resp_rdata = '0;
    logic          man_ack    = 1'b0;
    logic [DW-1:0] man_rdata  = '0;
    logic [DW-1:0] last_rdata = '0;

    assign bus.mem_ack   = auto_ack ? resp_ack   : man_ack;
    assign bus.mem_rdata = auto_ack ? resp_rdata : man_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // memory model: accepts each request, checks it against the issued access, acks after its delay
    mem_txn_t cur;
    bit       in_txn = 1'b0;
    int       busy_k = 0;
    always begin : responder
        @(negedge clk);
        resp_ack = 1'b0;
        if (!auto_ack || rst) begin
            in_txn = 1'b0;
        end else if (bus.mem_req) begin
            if (!in_txn) begin
                if (mem_q.size() == 0) begin
                    fail_event("unexpected_mem_req");
                end else begin
                    cur    = mem_q.pop_front();
                    in_txn = 1'b1;
                    busy_k = 0;
                end
            end
            if (in_txn) begin
                chk("mem_addr", bus.mem_addr, cur.addr);
                chk("mem_we", bus.mem_we, cur.we);
                chk("mem_wdata", bus.mem_wdata, cur.wdata);
                if (busy_k == cur.delay) begin
                    resp_ack   = 1'b1;
                    resp_rdata = cur.rdata;
                    in_txn     = 1'b0;
                end
                busy_k++;
            end
        end
    end

    // completion monitor: a stall run ending in a non-stall cycle is one finished access
    int stall_cnt = 0;
    always begin : cpl_monitor
        cpl_t e;
        @(negedge clk);
        if (!mon_en || rst) begin
            stall_cnt = 0;
        end else if (o_stall) begin
            stall_cnt++;
        end else if (stall_cnt > 0) begin
            if (cpl_q.size() == 0) begin
                fail_event("unexpected_completion");
            end else begin
                e = cpl_q.pop_front();
                chk("stall_cycles", stall_cnt, e.delay + 2);
                chk("cpu_rdata", o_cpu_rdata, e.rdata);
                chk("done_mem_req", bus.mem_req, 1'b0);
                chk("done_bus_err", o_bus_err, 1'b0);
            end
            stall_cnt = 0;
            done_cnt++;
        end
    end

    task automatic txn(input logic rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rd, input int delay, input bit hold);
        mem_txn_t m;
        cpl_t     c;
        int       n0;
        bit       got;
        m.addr  = addr;
        m.we    = ~rnw;
        m.wdata = wd;
        m.rdata = rd;
        m.delay = delay;
        mem_q.push_back(m);
        if (rnw) last_rdata = rd;
        c.delay = delay;
        c.rdata = last_rdata;
        cpl_q.push_back(c);
        i_cpu_memrq = 1'b1;
        i_cpu_rnw   = rnw;
        i_cpu_addr  = addr;
        i_cpu_wdata = wd;
        n0  = done_cnt;
        got = 1'b0;
        for (int c2 = 0; c2 < 40 && !got; c2++) begin
            @(posedge clk);
            if (done_cnt != n0) got = 1'b1;
        end
        #1;
        if (!got) fail_event("txn_timeout");
        if (!hold) begin
            i_cpu_memrq = 1'b0;
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int n;
        rst         = 1'b1;
        i_cpu_memrq = 1'b1;
        i_cpu_rnw   = 1'b1;
        i_cpu_addr  = 12'h123;
        i_cpu_wdata = 16'h5555;

        @(negedge clk);
        chk("stall_in_rst", o_stall, 1'b0);
        @(posedge clk); #1;
        i_cpu_memrq = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_rdata", o_cpu_rdata, 0);
        chk("rst_bus_err", o_bus_err, 1'b0);
        @(posedge clk); #1;
        rst      = 1'b0;
        auto_ack = 1'b1;
        mon_en   = 1'b1;
        @(negedge clk);
        chk("idle_stall", o_stall, 1'b0);
        chk("idle_mem_req", bus.mem_req, 1'b0);
        @(posedge clk); #1;

        txn(1'b1, 12'h00A, 16'h0000, 16'h1234, 0, 1'b0);
        txn(1'b0, 12'h0FF, 16'hBEEF, 16'h7777, 2, 1'b0);
        txn(1'b1, 12'h3C3, 16'h0000, 16'hA5A5, TIMEOUT - 1, 1'b1);
        txn(1'b1, 12'h001, 16'h0000, 16'h0F0F, 0, 1'b1);
        txn(1'b0, 12'h002, 16'h1111, 16'h2222, 1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom_range(1, 0)), AW'($urandom), DW'($urandom), DW'($urandom),
                $urandom_range(TIMEOUT - 1, 0), 1'($urandom_range(1, 0)));
        end
        i_cpu_memrq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_drained", mem_q.size(), 0);
        chk("cpl_q_drained", cpl_q.size(), 0);
        mon_en   = 1'b0;
        auto_ack = 1'b0;

        @(negedge clk);
        man_rdata = 16'hDEAD;
        man_ack   = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("spur_rdata", o_cpu_rdata, last_rdata);
        chk("spur_mem_req", bus.mem_req, 1'b0);
        chk("spur_stall", o_stall, 1'b0);

        @(posedge clk); #1;
        i_cpu_memrq = 1'b1;
        i_cpu_rnw   = 1'b1;
        i_cpu_addr  = 12'h2AA;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_bus_err) break;
            n++;
        end
        chk("timeout_stall_cycles", n, TIMEOUT + 1);
        chk("err_bus_err", o_bus_err, 1'b1);
        chk("err_stall", o_stall, 1'b1);
        chk("err_mem_req", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        i_cpu_memrq = 1'b0;
        @(negedge clk);
        man_rdata = 16'h4321;
        man_ack   = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("err_stall_stuck", o_stall, 1'b1);
        chk("err_sticky", o_bus_err, 1'b1);
        chk("err_rdata_hold", o_cpu_rdata, last_rdata);

        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("err_rst_stall", o_stall, 1'b0);
        @(posedge clk); #1;
        chk("err_rst_bus_err", o_bus_err, 1'b0);
        chk("err_rst_mem_req", bus.mem_req, 1'b0);
        chk("err_rst_mem_we", bus.mem_we, 1'b0);
        chk("err_rst_mem_addr", bus.mem_addr, 0);
        chk("err_rst_mem_wdata", bus.mem_wdata, 0);
        chk("err_rst_rdata", o_cpu_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", o_stall, 1'b0);

        @(posedge clk); #1;
        i_cpu_memrq = 1'b1;
        i_cpu_rnw   = 1'b1;
        i_cpu_addr  = 12'h155;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midbusy_req", bus.mem_req, 1'b1);
        rst       = 1'b1;
        man_rdata = 16'hBEEF;
        man_ack   = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_req", bus.mem_req, 1'b0);
        chk("abort_rdata", o_cpu_rdata, 0);
        chk("abort_stall", o_stall, 1'b0);
        man_ack     = 1'b0;
        i_cpu_memrq = 1'b0;
        rst         = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_stall", o_stall, 1'b0);
        chk("abort_idle_req", bus.mem_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
